// File: rtl/stb_dcache_arbiter.sv
// stb_dcache_arbiter: shares one dcache port between the store-buffer drain
// path and the load path of the LSU. One access is in flight at a time.
//
// Ports:
//   clk, rst_n                 clock and async active-low reset
//   stb2arb_*                  store drain request and fields (held until ack)
//   arb2stb_ack                one-cycle store-complete pulse
//   stb_full, stb_empty        store-buffer occupancy status
//   lsu2arb_*                  load request and fields (held until ack)
//   arb2lsu_ack                one-cycle load-complete pulse
//   arb2lsu_rdata              data of the last completed load
//   fence_i                    drain-all request pulse
//   arb2lsu_fence_done         one-cycle pulse once the store buffer is drained
//   arb2dcache_*               dcache request, fields, write enable, mem select
//   dcache2arb_ack / _rdata    dcache completion and read data
module stb_dcache_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTE_SEL_WIDTH = 4,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stb2arb_req,
  input  logic [ADDR_WIDTH-1:0]     stb2arb_addr,
  input  logic [DATA_WIDTH-1:0]     stb2arb_wdata,
  input  logic [BYTE_SEL_WIDTH-1:0] stb2arb_sel_byte,
  output logic                      arb2stb_ack,
  input  logic                      stb_full,
  input  logic                      stb_empty,
  input  logic                      lsu2arb_req,
  input  logic [ADDR_WIDTH-1:0]     lsu2arb_addr,
  input  logic [BYTE_SEL_WIDTH-1:0] lsu2arb_sel_byte,
  output logic                      arb2lsu_ack,
  output logic [DATA_WIDTH-1:0]     arb2lsu_rdata,
  input  logic                      fence_i,
  output logic                      arb2lsu_fence_done,
  output logic [ADDR_WIDTH-1:0]     arb2dcache_addr,
  output logic [DATA_WIDTH-1:0]     arb2dcache_wdata,
  output logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte,
  output logic                      arb2dcache_req,
  output logic                      arb2dcache_w_en,
  output logic                      arb2dcache_dmem_sel,
  input  logic                      dcache2arb_ack,
  input  logic [DATA_WIDTH-1:0]     dcache2arb_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    LOAD  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          starve_cnt_q, starve_cnt_d;
  logic                      fence_pending_q, fence_pending_d;
  logic                      stb_ack_q, stb_ack_d;
  logic                      lsu_ack_q, lsu_ack_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      fence_done_q, fence_done_d;
  logic [ADDR_WIDTH-1:0]     dc_addr_q, dc_addr_d;
  logic [DATA_WIDTH-1:0]     dc_wdata_q, dc_wdata_d;
  logic [BYTE_SEL_WIDTH-1:0] dc_sel_q, dc_sel_d;
  logic                      dc_req_q, dc_req_d;
  logic                      dc_w_en_q, dc_w_en_d;
  logic                      dc_dmem_q, dc_dmem_d;
  logic                      grant_store_c, grant_load_c;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      starve_cnt_q    <= '0;
      fence_pending_q <= 1'b0;
      stb_ack_q       <= 1'b0;
      lsu_ack_q       <= 1'b0;
      rdata_q         <= '0;
      fence_done_q    <= 1'b0;
      dc_addr_q       <= '0;
      dc_wdata_q      <= '0;
      dc_sel_q        <= '0;
      dc_req_q        <= 1'b0;
      dc_w_en_q       <= 1'b0;
      dc_dmem_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      starve_cnt_q    <= starve_cnt_d;
      fence_pending_q <= fence_pending_d;
      stb_ack_q       <= stb_ack_d;
      lsu_ack_q       <= lsu_ack_d;
      rdata_q         <= rdata_d;
      fence_done_q    <= fence_done_d;
      dc_addr_q       <= dc_addr_d;
      dc_wdata_q      <= dc_wdata_d;
      dc_sel_q        <= dc_sel_d;
      dc_req_q        <= dc_req_d;
      dc_w_en_q       <= dc_w_en_d;
      dc_dmem_q       <= dc_dmem_d;
    end
  end

  // Arbitration, access sequencing and fence tracking
  always_comb begin
    state_d         = state_q;
    starve_cnt_d    = starve_cnt_q;
    fence_pending_d = fence_pending_q;
    stb_ack_d       = 1'b0;
    lsu_ack_d       = 1'b0;
    rdata_d         = rdata_q;
    fence_done_d    = 1'b0;
    dc_addr_d       = dc_addr_q;
    dc_wdata_d      = dc_wdata_q;
    dc_sel_d        = dc_sel_q;
    dc_req_d        = dc_req_q;
    dc_w_en_d       = dc_w_en_q;
    dc_dmem_d       = dc_dmem_q;
    grant_store_c   = 1'b0;
    grant_load_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!stb2arb_req) begin
          starve_cnt_d = '0;
        end
        if (fence_pending_q && stb_empty && !stb2arb_req) begin
          fence_pending_d = 1'b0;
          fence_done_d    = 1'b1;
        end
        // The cycle carrying an ack pulse is a mandatory gap between grants.
        if (!(stb_ack_q || lsu_ack_q)) begin
          if (stb2arb_req &&
              (fence_pending_q || stb_full || (starve_cnt_q == STARVE_MAX))) begin
            grant_store_c = 1'b1;
          end else if (lsu2arb_req && !fence_pending_q) begin
            grant_load_c = 1'b1;
          end else if (stb2arb_req) begin
            grant_store_c = 1'b1;
          end
        end
        if (grant_store_c) begin
          state_d      = STORE;
          starve_cnt_d = '0;
          dc_addr_d    = stb2arb_addr;
          dc_wdata_d   = stb2arb_wdata;
          dc_sel_d     = stb2arb_sel_byte;
          dc_req_d     = 1'b1;
          dc_w_en_d    = 1'b1;
          dc_dmem_d    = 1'b1;
        end else if (grant_load_c) begin
          state_d    = LOAD;
          dc_addr_d  = lsu2arb_addr;
          dc_wdata_d = '0;
          dc_sel_d   = lsu2arb_sel_byte;
          dc_req_d   = 1'b1;
          dc_w_en_d  = 1'b0;
          dc_dmem_d  = 1'b1;
          // Only loads that bypass a waiting store count toward starvation.
          if (stb2arb_req && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end
      end
      STORE, LOAD: begin
        if (dcache2arb_ack) begin
          state_d   = IDLE;
          dc_req_d  = 1'b0;
          dc_w_en_d = 1'b0;
          dc_dmem_d = 1'b0;
          if (state_q == STORE) begin
            stb_ack_d = 1'b1;
          end else begin
            lsu_ack_d = 1'b1;
            rdata_d   = dcache2arb_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new fence wins over completion of the previous one.
    if (fence_i) begin
      fence_pending_d = 1'b1;
    end
  end

  assign arb2stb_ack         = stb_ack_q;
  assign arb2lsu_ack         = lsu_ack_q;
  assign arb2lsu_rdata       = rdata_q;
  assign arb2lsu_fence_done  = fence_done_q;
  assign arb2dcache_addr     = dc_addr_q;
  assign arb2dcache_wdata    = dc_wdata_q;
  assign arb2dcache_sel_byte = dc_sel_q;
  assign arb2dcache_req      = dc_req_q;
  assign arb2dcache_w_en     = dc_w_en_q;
  assign arb2dcache_dmem_sel = dc_dmem_q;

endmodule

// File: tb/tb_stb_dcache_arbiter.sv
// Directed bench for stb_dcache_arbiter with requester/dcache models and an
// in-order scoreboard of expected dcache accesses.
module tb_stb_dcache_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam logic [DW-1:0] RD_KEY = 32'h12345678;

  typedef struct packed {
    logic          w_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] sel;
    logic [DW-1:0] rdata;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stb2arb_req;
  logic [AW-1:0] stb2arb_addr;
  logic [DW-1:0] stb2arb_wdata;
  logic [SW-1:0] stb2arb_sel_byte;
  logic          arb2stb_ack;
  logic          stb_full, stb_empty;
  logic          lsu2arb_req;
  logic [AW-1:0] lsu2arb_addr;
  logic [SW-1:0] lsu2arb_sel_byte;
  logic          arb2lsu_ack;
  logic [DW-1:0] arb2lsu_rdata;
  logic          fence_i;
  logic          arb2lsu_fence_done;
  logic [AW-1:0] arb2dcache_addr;
  logic [DW-1:0] arb2dcache_wdata;
  logic [SW-1:0] arb2dcache_sel_byte;
  logic          arb2dcache_req, arb2dcache_w_en, arb2dcache_dmem_sel;
  logic          dcache2arb_ack;
  logic [DW-1:0] dcache2arb_rdata;

  int   total = 0;
  int   bad   = 0;
  acc_t stq[$];
  acc_t ldq[$];
  acc_t expq[$];
  bit   full_mode;
  int   fd_cyc, fd_count, ld_grant_cyc, first_req_cyc, stb_ack_cyc, req_hi_w;
  logic [DW-1:0] last_rd;

  stb_dcache_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .stb2arb_req(stb2arb_req), .stb2arb_addr(stb2arb_addr),
    .stb2arb_wdata(stb2arb_wdata), .stb2arb_sel_byte(stb2arb_sel_byte),
    .arb2stb_ack(arb2stb_ack), .stb_full(stb_full), .stb_empty(stb_empty),
    .lsu2arb_req(lsu2arb_req), .lsu2arb_addr(lsu2arb_addr),
    .lsu2arb_sel_byte(lsu2arb_sel_byte), .arb2lsu_ack(arb2lsu_ack),
    .arb2lsu_rdata(arb2lsu_rdata), .fence_i(fence_i),
    .arb2lsu_fence_done(arb2lsu_fence_done),
    .arb2dcache_addr(arb2dcache_addr), .arb2dcache_wdata(arb2dcache_wdata),
    .arb2dcache_sel_byte(arb2dcache_sel_byte), .arb2dcache_req(arb2dcache_req),
    .arb2dcache_w_en(arb2dcache_w_en), .arb2dcache_dmem_sel(arb2dcache_dmem_sel),
    .dcache2arb_ack(dcache2arb_ack), .dcache2arb_rdata(dcache2arb_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic acc_t mk_st(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [SW-1:0] s);
    acc_t e;
    e.w_en = 1'b1; e.addr = a; e.wdata = d; e.sel = s; e.rdata = '0;
    return e;
  endfunction

  function automatic acc_t mk_ld(input logic [AW-1:0] a, input logic [SW-1:0] s);
    acc_t e;
    e.w_en = 1'b0; e.addr = a; e.wdata = '0; e.sel = s; e.rdata = a ^ RD_KEY;
    return e;
  endfunction

  // Requesters present the head of their queue and hold it until acked.
  task automatic drive_reqs(input int cyc, input int ld_delay);
    stb2arb_req = (stq.size() != 0);
    stb_empty   = (stq.size() == 0);
    stb_full    = full_mode && (stq.size() != 0);
    if (stq.size() != 0) begin
      stb2arb_addr     = stq[0].addr;
      stb2arb_wdata    = stq[0].wdata;
      stb2arb_sel_byte = stq[0].sel;
    end
    lsu2arb_req = (ldq.size() != 0) && (cyc >= ld_delay);
    if (ldq.size() != 0) begin
      lsu2arb_addr     = ldq[0].addr;
      lsu2arb_sel_byte = ldq[0].sel;
    end
  endtask

  // Runs queued traffic to completion; dcache acks in the lat-th request cycle.
  task automatic run(input int lat, input int ld_delay, input bit fence0, input int max_cyc);
    int   cyc;
    int   wait_cnt;
    bit   prev_req;
    bit   done;
    bit   cur_valid;
    acc_t cur;
    cyc = 0; wait_cnt = 0; prev_req = 1'b0; done = 1'b0; cur_valid = 1'b0; cur = '0;
    fd_cyc = -1; fd_count = 0; ld_grant_cyc = -1; first_req_cyc = -1;
    stb_ack_cyc = -1; req_hi_w = 0;
    drive_reqs(0, ld_delay);
    fence_i = fence0;
    while (!done && cyc < max_cyc) begin
      @(posedge clk); #1; cyc++;
      fence_i = 1'b0;
      if (arb2lsu_fence_done) begin
        fd_count++;
        if (fd_cyc < 0) fd_cyc = cyc;
      end
      if (arb2dcache_req && arb2dcache_w_en) req_hi_w++;
      if (arb2dcache_req && !prev_req) begin
        if (first_req_cyc < 0) first_req_cyc = cyc;
        wait_cnt = 0;
        if (expq.size() == 0) begin
          chk("unexpected_grant", 128'(1), 128'(0));
        end else begin
          cur = expq.pop_front();
          cur_valid = 1'b1;
          chk("grant_w_en", 128'(arb2dcache_w_en), 128'(cur.w_en));
          chk("grant_addr", 128'(arb2dcache_addr), 128'(cur.addr));
          chk("grant_wdata", 128'(arb2dcache_wdata), 128'(cur.wdata));
          chk("grant_sel", 128'(arb2dcache_sel_byte), 128'(cur.sel));
          chk("grant_dmem_sel", 128'(arb2dcache_dmem_sel), 128'(1));
          if (!cur.w_en && ld_grant_cyc < 0) ld_grant_cyc = cyc;
        end
      end
      prev_req = arb2dcache_req;
      if (arb2stb_ack) begin
        chk("stb_ack_kind", 128'(cur_valid && cur.w_en), 128'(1));
        if (stb_ack_cyc < 0) stb_ack_cyc = cyc;
        if (stq.size() != 0) void'(stq.pop_front());
        cur_valid = 1'b0;
      end
      if (arb2lsu_ack) begin
        chk("lsu_ack_kind", 128'(cur_valid && !cur.w_en), 128'(1));
        chk("load_rdata", 128'(arb2lsu_rdata), 128'(cur.rdata));
        last_rd = cur.rdata;
        if (ldq.size() != 0) void'(ldq.pop_front());
        cur_valid = 1'b0;
      end
      if (arb2dcache_req) begin
        wait_cnt++;
        dcache2arb_ack = (wait_cnt == lat);
      end else begin
        dcache2arb_ack = 1'b0;
      end
      dcache2arb_rdata = dcache2arb_ack ? (arb2dcache_addr ^ RD_KEY) : 32'hBAD0BAD0;
      drive_reqs(cyc, ld_delay);
      done = (stq.size() == 0) && (ldq.size() == 0) && (expq.size() == 0) &&
             !arb2dcache_req && !arb2stb_ack && !arb2lsu_ack;
    end
    chk("run_complete", 128'(done), 128'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 128'({arb2stb_ack, arb2lsu_ack, arb2lsu_fence_done,
                              arb2dcache_req, arb2dcache_w_en, arb2dcache_dmem_sel}), 128'(0));
    chk({tag, "_rdata"}, 128'(arb2lsu_rdata), 128'(0));
    chk({tag, "_fields"}, 128'({arb2dcache_addr, arb2dcache_wdata, arb2dcache_sel_byte}), 128'(0));
  endtask

  initial begin
    acc_t st0, st1, ld0;
    acc_t lds[5];
    rst_n = 1'b0; full_mode = 1'b0; fence_i = 1'b0;
    stb2arb_req = 1'b0; stb2arb_addr = '0; stb2arb_wdata = '0; stb2arb_sel_byte = '0;
    stb_full = 1'b0; stb_empty = 1'b1;
    lsu2arb_req = 1'b0; lsu2arb_addr = '0; lsu2arb_sel_byte = '0;
    dcache2arb_ack = 1'b0; dcache2arb_rdata = '0; last_rd = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store only, dcache acks in the fifth request cycle
    st0 = mk_st(32'h100, 32'hDEADBEEF, 4'hF);
    stq.push_back(st0);
    expq.push_back(st0);
    run(5, 0, 1'b0, 40);
    chk("store_first_req_cycle", 128'(first_req_cyc), 128'(1));
    chk("store_req_cycles", 128'(req_hi_w), 128'(5));
    chk("store_ack_cycle", 128'(stb_ack_cyc), 128'(6));

    // Fence with empty buffer, then a back-to-back fence on the done pulse
    fence_i = 1'b1;
    @(posedge clk); #1; fence_i = 1'b0;
    chk("fence_empty_c1", 128'(arb2lsu_fence_done), 128'(0));
    @(posedge clk); #1;
    chk("fence_empty_c2", 128'(arb2lsu_fence_done), 128'(1));
    fence_i = 1'b1;
    @(posedge clk); #1; fence_i = 1'b0;
    chk("fence_again_c3", 128'(arb2lsu_fence_done), 128'(0));
    @(posedge clk); #1;
    chk("fence_again_c4", 128'(arb2lsu_fence_done), 128'(1));
    @(posedge clk); #1;
    chk("fence_again_c5", 128'({arb2lsu_fence_done, arb2dcache_req}), 128'(0));

    // Starvation limit: L L L L S L
    for (int i = 0; i < 5; i++) begin
      lds[i] = mk_ld(AW'(4 * i), 4'hF);
      ldq.push_back(lds[i]);
    end
    st1 = mk_st(32'h200, 32'hCAFEF00D, 4'h3);
    stq.push_back(st1);
    for (int i = 0; i < 4; i++) expq.push_back(lds[i]);
    expq.push_back(st1);
    expq.push_back(lds[4]);
    run(1, 0, 1'b0, 200);

    // dcache ack held high while idle
    dcache2arb_ack = 1'b1;
    dcache2arb_rdata = 32'hFFFF0000;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("idle_ack_ignored", 128'({arb2stb_ack, arb2lsu_ack, arb2dcache_req}), 128'(0));
    end
    chk("idle_rdata_held", 128'(arb2lsu_rdata), 128'(last_rd));
    dcache2arb_ack = 1'b0;

    // stb_full: store wins over a simultaneous load
    full_mode = 1'b1;
    st0 = mk_st(32'h404, 32'h0BADF00D, 4'h1);
    ld0 = mk_ld(32'h500, 4'hC);
    stq.push_back(st0);
    ldq.push_back(ld0);
    expq.push_back(st0);
    expq.push_back(ld0);
    run(2, 0, 1'b0, 60);
    full_mode = 1'b0;

    // Fence drains two stores before the pending load
    st0 = mk_st(32'h600, 32'h11111111, 4'hF);
    st1 = mk_st(32'h604, 32'h22222222, 4'h6);
    ld0 = mk_ld(32'h700, 4'hF);
    stq.push_back(st0);
    stq.push_back(st1);
    ldq.push_back(ld0);
    expq.push_back(st0);
    expq.push_back(st1);
    expq.push_back(ld0);
    run(2, 1, 1'b1, 80);
    chk("fence_done_count", 128'(fd_count), 128'(1));
    chk("fence_before_load", 128'((fd_cyc > 0) && (fd_cyc < ld_grant_cyc)), 128'(1));

    // Reset in the middle of a load access
    lsu2arb_addr = 32'h300; lsu2arb_sel_byte = 4'hF; lsu2arb_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midload_active", 128'({arb2dcache_req, arb2dcache_w_en}), 128'(2'b10));
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    lsu2arb_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_reset_quiet", 128'({arb2lsu_ack, arb2stb_ack, arb2dcache_req}), 128'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
